// File: rtl/brot_iter_engine.sv
// Mandelbrot per-pixel iteration engine: one z = z^2 + c step per clock,
// reporting the escape iteration (or the limit) through a valid/ready result port.
module brot_iter_engine #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 28,
    parameter int ITER_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] c_re,
    input  logic signed [DATA_W-1:0] c_im,
    input  logic        [ITER_W-1:0] max_iter,
    input  logic                     abort,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [ITER_W-1:0] out_iter,
    output logic                     out_escaped
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PW = 2 * DATA_W;
    // |z|^2 escape threshold 4.0 in the Q(2*FRAC_W) scale of the squared magnitude
    localparam logic [PW:0] ESC_LIMIT = {{(PW - 2){1'b0}}, 3'b100} << (2 * FRAC_W);

    function automatic logic signed [PW-1:0] sext(input logic signed [DATA_W-1:0] v);
        return {{DATA_W{v[DATA_W-1]}}, v};
    endfunction

    function automatic logic [PW:0] mag_sq(input logic signed [PW-1:0] sq_a,
                                           input logic signed [PW-1:0] sq_b);
        return {1'b0, sq_a} + {1'b0, sq_b};
    endfunction

    state_t                     state_r, state_s;
    logic signed [DATA_W-1:0]   z_re_r, z_im_r, c_re_r, c_im_r;
    logic        [ITER_W-1:0]   max_iter_r, count_r, out_iter_r;
    logic                       out_escaped_r, in_ready_r, busy_r, out_valid_r;

    logic signed [PW-1:0]       sq_re_s, sq_im_s, cross_s, diff_s;
    logic        [PW:0]         mag_s;
    logic signed [DATA_W-1:0]   z_re_next_s, z_im_next_s;
    logic                       escape_s, limit_s, accept_s, step_s, finish_s;

    // Squares, magnitude and the next z value for the current iterate
    always_comb begin
        sq_re_s     = sext(z_re_r) * sext(z_re_r);
        sq_im_s     = sext(z_im_r) * sext(z_im_r);
        cross_s     = sext(z_re_r) * sext(z_im_r);
        diff_s      = sq_re_s - sq_im_s;
        mag_s       = mag_sq(sq_re_s, sq_im_s);
        z_re_next_s = DATA_W'(diff_s >>> FRAC_W) + c_re_r;
        z_im_next_s = DATA_W'(cross_s >>> (FRAC_W - 1)) + c_im_r;
        escape_s    = (mag_s > ESC_LIMIT);
        limit_s     = (count_r == max_iter_r);
    end

    // Next-state logic and datapath enables
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_ITER;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_ITER: begin
                // abort outranks a result that would otherwise complete this cycle
                if (abort) begin
                    state_s  = ST_IDLE;
                end else if (escape_s || limit_s) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    step_s   = 1'b1;
                    state_s  = ST_ITER;
                end
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake/status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
        end
    end

    // Job capture, iteration datapath and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            z_re_r        <= {DATA_W{1'b0}};
            z_im_r        <= {DATA_W{1'b0}};
            c_re_r        <= {DATA_W{1'b0}};
            c_im_r        <= {DATA_W{1'b0}};
            max_iter_r    <= {ITER_W{1'b0}};
            count_r       <= {ITER_W{1'b0}};
            out_iter_r    <= {ITER_W{1'b0}};
            out_escaped_r <= 1'b0;
        end else if (accept_s) begin
            z_re_r     <= {DATA_W{1'b0}};
            z_im_r     <= {DATA_W{1'b0}};
            c_re_r     <= c_re;
            c_im_r     <= c_im;
            max_iter_r <= max_iter;
            count_r    <= {ITER_W{1'b0}};
        end else if (step_s) begin
            z_re_r  <= z_re_next_s;
            z_im_r  <= z_im_next_s;
            count_r <= count_r + {{(ITER_W - 1){1'b0}}, 1'b1};
        end else if (finish_s) begin
            // count_r equals max_iter_r on a pure limit exit, so one source covers both cases
            out_iter_r    <= count_r;
            out_escaped_r <= escape_s;
        end else begin
            z_re_r <= z_re_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign out_valid   = out_valid_r;
    assign out_iter    = out_iter_r;
    assign out_escaped = out_escaped_r;

endmodule
